// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared constants for the MEM pipeline stage and its data memory.
//   ADDR_BITS_DEFAULT : default word-address width (2^8 = 256 words)
//   DATA_W            : data / address word width
//   REG_ADDR_W        : register-file address width
//   CNT_W             : committed-store counter width
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int ADDR_BITS_DEFAULT = 8;
    localparam int DATA_W            = 32;
    localparam int REG_ADDR_W        = 5;
    localparam int CNT_W             = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A byte address is a legal word access only when its two LSBs are zero.
    function automatic logic word_aligned(input logic [DATA_W-1:0] byte_addr);
        return (byte_addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-addressed data RAM: asynchronous read, synchronous write.
// Contents are never cleared; there is deliberately no reset input.
// Ports:
//   CLOCK    in   write clock
//   we_i     in   write enable, writes wdata_i at addr_i on rising edge
//   addr_i   in   word index (shared by read and write)
//   wdata_i  in   write data
//   rdata_o  out  combinational read of the word at addr_i
// ---------------------------------------------------------------------------
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic                 CLOCK,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLOCK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read is combinational, so a load+store to the same word in one cycle
    // observes the pre-write contents.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage: data-memory access, branch resolution towards fetch,
// MEM/WB pipeline register, sticky misalignment fault and a saturating
// count of committed stores.
// Ports:
//   CLOCK, RESET                   clock, synchronous active-high reset
//   RegWriteEN_In, Mem2RegSEL_In,
//   MemWriteEN_In, Branch_In,
//   ZeroFlag_In                    EX/MEM control bits
//   ALUResult_In                   byte address for loads/stores, or pass-through result
//   WriteData_In                   store data
//   WriteBackRegAddr_In            destination register
//   PC_In                          branch target from EX
//   PCSrc_Out, BranchTarget_Out    combinational branch select / target
//   RegWriteEN_Out, Mem2RegSEL_Out,
//   ReadData_Out, ALUResult_Out,
//   WriteBackRegAddr_Out           registered MEM/WB outputs
//   MisalignFault_Out              sticky misaligned-access flag
//   StoreCount_Out                 saturating committed-store counter
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic                  CLOCK,
    input  logic                  RESET,

    input  logic                  RegWriteEN_In,
    input  logic                  Mem2RegSEL_In,
    input  logic                  MemWriteEN_In,
    input  logic                  Branch_In,
    input  logic                  ZeroFlag_In,
    input  logic [DATA_W-1:0]     ALUResult_In,
    input  logic [DATA_W-1:0]     WriteData_In,
    input  logic [REG_ADDR_W-1:0] WriteBackRegAddr_In,
    input  logic [DATA_W-1:0]     PC_In,

    output logic                  PCSrc_Out,
    output logic [DATA_W-1:0]     BranchTarget_Out,

    output logic                  RegWriteEN_Out,
    output logic                  Mem2RegSEL_Out,
    output logic [DATA_W-1:0]     ReadData_Out,
    output logic [DATA_W-1:0]     ALUResult_Out,
    output logic [REG_ADDR_W-1:0] WriteBackRegAddr_Out,
    output logic                  MisalignFault_Out,
    output logic [CNT_W-1:0]      StoreCount_Out
);

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic [ADDR_BITS-1:0] word_idx;
    logic                 misaligned;
    logic                 load_fault;
    logic                 store_fault;
    logic                 store_commit;
    logic [DATA_W-1:0]    mem_rdata;

    // Bits above the word index are dropped, so addresses wrap around memory.
    assign word_idx     = ALUResult_In[ADDR_BITS+1:2];
    assign misaligned   = ~word_aligned(ALUResult_In);
    assign load_fault   = Mem2RegSEL_In & misaligned;
    assign store_fault  = MemWriteEN_In & misaligned;
    // Reset discards the instruction in flight, including its store.
    assign store_commit = MemWriteEN_In & ~misaligned & ~RESET;

    // -----------------------------------------------------------------------
    // Branch resolution (no register in the path)
    // -----------------------------------------------------------------------
    assign PCSrc_Out        = Branch_In & ZeroFlag_In;
    assign BranchTarget_Out = PC_In;

    // -----------------------------------------------------------------------
    // Data memory
    // -----------------------------------------------------------------------
    data_memory #(
        .ADDR_BITS (ADDR_BITS)
    ) u_data_memory (
        .CLOCK   (CLOCK),
        .we_i    (store_commit),
        .addr_i  (word_idx),
        .wdata_i (WriteData_In),
        .rdata_o (mem_rdata)
    );

    // -----------------------------------------------------------------------
    // MEM/WB register, fault flag, store counter
    // -----------------------------------------------------------------------
    logic                  reg_write_d,  reg_write_q;
    logic                  mem2reg_d,    mem2reg_q;
    logic [DATA_W-1:0]     read_data_d,  read_data_q;
    logic [DATA_W-1:0]     alu_result_d, alu_result_q;
    logic [REG_ADDR_W-1:0] wb_addr_d,    wb_addr_q;
    logic                  fault_d,      fault_q;
    logic [CNT_W-1:0]      store_cnt_d,  store_cnt_q;

    always_comb begin
        reg_write_d  = RegWriteEN_In;
        mem2reg_d    = Mem2RegSEL_In;
        read_data_d  = mem_rdata;
        alu_result_d = ALUResult_In;
        wb_addr_d    = WriteBackRegAddr_In;
        fault_d      = fault_q | load_fault | store_fault;
        store_cnt_d  = store_cnt_q;

        // A misaligned load must not corrupt the register file: squash the
        // write-back and return zero data.
        if (load_fault) begin
            reg_write_d = 1'b0;
            read_data_d = '0;
        end

        if (store_commit && (store_cnt_q != CNT_MAX)) begin
            store_cnt_d = store_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            reg_write_q  <= 1'b0;
            mem2reg_q    <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            wb_addr_q    <= '0;
            fault_q      <= 1'b0;
            store_cnt_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem2reg_q    <= mem2reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            wb_addr_q    <= wb_addr_d;
            fault_q      <= fault_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign RegWriteEN_Out       = reg_write_q;
    assign Mem2RegSEL_Out       = mem2reg_q;
    assign ReadData_Out         = read_data_q;
    assign ALUResult_Out        = alu_result_q;
    assign WriteBackRegAddr_Out = wb_addr_q;
    assign MisalignFault_Out    = fault_q;
    assign StoreCount_Out       = store_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: directed vector table, randomized
// traffic against a word-array reference model, and counter saturation.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Branch_In, ZeroFlag_In;
    logic [31:0] ALUResult_In, WriteData_In, PC_In;
    logic [4:0]  WriteBackRegAddr_In;
    logic        PCSrc_Out;
    logic [31:0] BranchTarget_Out;
    logic        RegWriteEN_Out, Mem2RegSEL_Out;
    logic [31:0] ReadData_Out, ALUResult_Out;
    logic [4:0]  WriteBackRegAddr_Out;
    logic        MisalignFault_Out;
    logic [15:0] StoreCount_Out;

    mem_stage dut (
        .CLOCK                (CLOCK),
        .RESET                (RESET),
        .RegWriteEN_In        (RegWriteEN_In),
        .Mem2RegSEL_In        (Mem2RegSEL_In),
        .MemWriteEN_In        (MemWriteEN_In),
        .Branch_In            (Branch_In),
        .ZeroFlag_In          (ZeroFlag_In),
        .ALUResult_In         (ALUResult_In),
        .WriteData_In         (WriteData_In),
        .WriteBackRegAddr_In  (WriteBackRegAddr_In),
        .PC_In                (PC_In),
        .PCSrc_Out            (PCSrc_Out),
        .BranchTarget_Out     (BranchTarget_Out),
        .RegWriteEN_Out       (RegWriteEN_Out),
        .Mem2RegSEL_Out       (Mem2RegSEL_Out),
        .ReadData_Out         (ReadData_Out),
        .ALUResult_Out        (ALUResult_Out),
        .WriteBackRegAddr_Out (WriteBackRegAddr_Out),
        .MisalignFault_Out    (MisalignFault_Out),
        .StoreCount_Out       (StoreCount_Out)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rwen, input logic m2r, input logic mwen,
                         input logic br, input logic zf, input logic [31:0] alu,
                         input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] wb);
        RESET               = rst;
        RegWriteEN_In       = rwen;
        Mem2RegSEL_In       = m2r;
        MemWriteEN_In       = mwen;
        Branch_In           = br;
        ZeroFlag_In         = zf;
        ALUResult_In        = alu;
        WriteData_In        = wdata;
        PC_In               = pc;
        WriteBackRegAddr_In = wb;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    typedef struct packed {
        logic        rst, rwen, m2r, mwen, br, zf;
        logic [31:0] alu, wdata, pc;
        logic [4:0]  wb;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_rwen;
        logic [4:0]  exp_wb;
        logic        exp_fault;
        logic [15:0] exp_cnt;
        logic        exp_pcsrc;
    } vec_t;

    vec_t vecs [15];

    // Reference model state
    logic [31:0] mmem [256];
    int          mcnt;
    logic        mfault;

    initial begin
        // rst rwen m2r mwen br zf  alu          wdata         pc        wb  chk rd            rwen wb fault cnt pcsrc
        vecs[0]  = '{0,0,0,1,0,0, 32'h10,  32'hDEADBEEF, 32'h0,  5'd0, 0, 32'h0,        0, 5'd0, 0, 16'd1, 0};
        vecs[1]  = '{0,1,1,0,0,0, 32'h10,  32'h0,        32'h0,  5'd7, 1, 32'hDEADBEEF, 1, 5'd7, 0, 16'd1, 0};
        vecs[2]  = '{0,0,0,1,0,0, 32'h8,   32'h0000AAAA, 32'h0,  5'd0, 0, 32'h0,        0, 5'd0, 0, 16'd2, 0};
        vecs[3]  = '{0,0,0,0,1,1, 32'h0,   32'h0,        32'h40, 5'd0, 0, 32'h0,        0, 5'd0, 0, 16'd2, 1};
        vecs[4]  = '{0,0,0,0,1,0, 32'h0,   32'h0,        32'h40, 5'd0, 0, 32'h0,        0, 5'd0, 0, 16'd2, 0};
        vecs[5]  = '{0,0,0,1,0,0, 32'h400, 32'h1,        32'h0,  5'd0, 0, 32'h0,        0, 5'd0, 0, 16'd3, 0};
        vecs[6]  = '{0,1,1,0,0,0, 32'h0,   32'h0,        32'h0,  5'd2, 1, 32'h1,        1, 5'd2, 0, 16'd3, 0};
        vecs[7]  = '{0,1,1,1,0,0, 32'h10,  32'h12345678, 32'h0,  5'd4, 1, 32'hDEADBEEF, 1, 5'd4, 0, 16'd4, 0};
        vecs[8]  = '{0,1,1,0,0,0, 32'h10,  32'h0,        32'h0,  5'd5, 1, 32'h12345678, 1, 5'd5, 0, 16'd4, 0};
        vecs[9]  = '{0,0,0,1,0,0, 32'h13,  32'h00000BAD, 32'h0,  5'd0, 0, 32'h0,        0, 5'd0, 1, 16'd4, 0};
        vecs[10] = '{0,1,1,0,0,0, 32'h10,  32'h0,        32'h0,  5'd6, 1, 32'h12345678, 1, 5'd6, 1, 16'd4, 0};
        vecs[11] = '{0,1,1,0,0,0, 32'h22,  32'h0,        32'h0,  5'd9, 1, 32'h0,        0, 5'd9, 1, 16'd4, 0};
        vecs[12] = '{1,1,1,1,1,1, 32'h8,   32'h55,       32'h80, 5'd3, 1, 32'h0,        0, 5'd0, 0, 16'd0, 1};
        vecs[13] = '{0,1,1,0,0,0, 32'h8,   32'h0,        32'h0,  5'd3, 1, 32'h0000AAAA, 1, 5'd3, 0, 16'd0, 0};
        vecs[14] = '{0,1,1,0,0,0, 32'h10,  32'h0,        32'h0,  5'd1, 1, 32'h12345678, 1, 5'd1, 0, 16'd0, 0};

        // ---------------- reset state ----------------
        drive(1, 1, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h0, 5'd31);
        tick();
        tick();
        check("reset_rwen",  {31'b0, RegWriteEN_Out},    32'h0);
        check("reset_m2r",   {31'b0, Mem2RegSEL_Out},    32'h0);
        check("reset_rd",    ReadData_Out,               32'h0);
        check("reset_alu",   ALUResult_Out,              32'h0);
        check("reset_wb",    {27'b0, WriteBackRegAddr_Out}, 32'h0);
        check("reset_fault", {31'b0, MisalignFault_Out}, 32'h0);
        check("reset_cnt",   {16'b0, StoreCount_Out},    32'h0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].rwen, vecs[i].m2r, vecs[i].mwen, vecs[i].br, vecs[i].zf,
                  vecs[i].alu, vecs[i].wdata, vecs[i].pc, vecs[i].wb);
            #1;
            check($sformatf("vec%0d_pcsrc", i),  {31'b0, PCSrc_Out}, {31'b0, vecs[i].exp_pcsrc});
            check($sformatf("vec%0d_target", i), BranchTarget_Out, vecs[i].pc);
            tick();
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rd", i), ReadData_Out, vecs[i].exp_rd);
            check($sformatf("vec%0d_rwen", i),  {31'b0, RegWriteEN_Out},    {31'b0, vecs[i].exp_rwen});
            check($sformatf("vec%0d_wb", i),    {27'b0, WriteBackRegAddr_Out}, {27'b0, vecs[i].exp_wb});
            check($sformatf("vec%0d_fault", i), {31'b0, MisalignFault_Out}, {31'b0, vecs[i].exp_fault});
            check($sformatf("vec%0d_cnt", i),   {16'b0, StoreCount_Out},    {16'b0, vecs[i].exp_cnt});
        end

        // ---------------- randomized traffic vs reference model ----------------
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        mcnt   = 0;
        mfault = 1'b0;

        // Fill every word so all later reads have a known value; upper
        // address bits are randomized to exercise wrap-around.
        for (int w = 0; w < 256; w++) begin
            logic [31:0] hi, d;
            hi = $urandom;
            d  = $urandom;
            drive(0, 0, 0, 1, 0, 0, {hi[31:10], w[7:0], 2'b00}, d, 32'h0, 5'd0);
            tick();
            mmem[w] = d;
            mcnt++;
        end
        check("fill_cnt", {16'b0, StoreCount_Out}, 32'd256);

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] r, alu, wdata, pc, exp_rd;
            logic        rst, rwen, m2r, mwen, br, zf, mis, exp_rwen;
            logic [4:0]  wb;
            int          idx;
            r     = $urandom;
            rst   = ($urandom_range(0, 63) == 0);
            rwen  = r[0];
            m2r   = r[1];
            mwen  = r[2];
            br    = r[3];
            zf    = r[4];
            wb    = r[9:5];
            alu   = $urandom;
            if ($urandom_range(0, 3) != 0) alu = {alu[31:2], 2'b00};
            wdata = $urandom;
            pc    = $urandom;

            idx = int'((alu / 4) % 256);
            mis = (alu % 4) != 0;

            drive(rst, rwen, m2r, mwen, br, zf, alu, wdata, pc, wb);
            #1;
            check("rnd_pcsrc",  {31'b0, PCSrc_Out}, {31'b0, br && zf});
            check("rnd_target", BranchTarget_Out, pc);

            if (rst) begin
                exp_rd   = 32'h0;
                exp_rwen = 1'b0;
                mcnt     = 0;
                mfault   = 1'b0;
            end else begin
                exp_rd   = (m2r && mis) ? 32'h0 : mmem[idx];
                exp_rwen = rwen && !(m2r && mis);
                if (mis && (m2r || mwen)) mfault = 1'b1;
                if (mwen && !mis) begin
                    mmem[idx] = wdata;
                    if (mcnt < 65535) mcnt++;
                end
            end

            tick();
            check("rnd_rd",    ReadData_Out, exp_rd);
            check("rnd_rwen",  {31'b0, RegWriteEN_Out}, {31'b0, exp_rwen});
            check("rnd_m2r",   {31'b0, Mem2RegSEL_Out}, rst ? 32'h0 : {31'b0, m2r});
            check("rnd_alu",   ALUResult_Out, rst ? 32'h0 : alu);
            check("rnd_wb",    {27'b0, WriteBackRegAddr_Out}, rst ? 32'h0 : {27'b0, wb});
            check("rnd_fault", {31'b0, MisalignFault_Out}, {31'b0, mfault});
            check("rnd_cnt",   {16'b0, StoreCount_Out}, mcnt);
        end

        // ---------------- counter saturation ----------------
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        check("sat_start", {16'b0, StoreCount_Out}, 32'h0);
        for (int s = 1; s <= 65536; s++) begin
            drive(0, 0, 0, 1, 0, 0, 32'h40, s, 32'h0, 5'd0);
            tick();
            if (s == 1)     check("sat_first",  {16'b0, StoreCount_Out}, 32'h1);
            if (s == 65534) check("sat_65534",  {16'b0, StoreCount_Out}, 32'hFFFE);
            if (s == 65535) check("sat_65535",  {16'b0, StoreCount_Out}, 32'hFFFF);
            if (s == 65536) check("sat_65536",  {16'b0, StoreCount_Out}, 32'hFFFF);
        end
        drive(0, 1, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 5'd8);
        tick();
        check("sat_last_data", ReadData_Out, 32'd65536);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
